// File: rtl/multicycle_control32.sv
// Multi-cycle MIPS control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and emits one-cycle datapath strobes, with a parameterised memory access latency.
module multicycle_control32 #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Function_opcode,
    input  logic       Zero,
    input  logic       stall,
    output logic [2:0] state,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       PCInc,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       RegDST,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       Jr,
    output logic       Jmp,
    output logic       Jal,
    output logic       Branch,
    output logic       nBranch,
    output logic       I_format,
    output logic       Sftmd,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic       instr_done
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MEM_LATENCY - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [2:0]       next_state;
    logic             r_format, lw_op, sw_op, legal_op;
    logic             mem_read_raw, ir_write_raw, pc_inc_raw, pc_write_raw;
    logic             reg_write_raw, mem_write_raw, illegal_raw, done_raw;
    logic             block_strobes;

    // Decode levels follow the single-cycle control32 encoding exactly
    assign r_format = (Opcode == 6'b000000);
    assign I_format = (Opcode[5:3] == 3'b001);
    assign lw_op    = (Opcode == 6'b100011);
    assign sw_op    = (Opcode == 6'b101011);
    assign Branch   = (Opcode == 6'b000100);
    assign nBranch  = (Opcode == 6'b000101);
    assign Jmp      = (Opcode == 6'b000010);
    assign Jal      = (Opcode == 6'b000011);
    assign Jr       = r_format && (Function_opcode == 6'b001000);
    assign RegDST   = r_format;
    assign ALUSrc   = I_format || lw_op || sw_op;
    assign MemtoReg = lw_op;
    assign Sftmd    = r_format && (Function_opcode[5:3] == 3'b000);
    assign ALUOp    = {(r_format || I_format), (Branch || nBranch)};
    assign legal_op = r_format || I_format || lw_op || sw_op || Branch || nBranch || Jmp || Jal;

    always_comb begin
        next_state    = state;
        next_cnt      = cnt;
        mem_read_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        pc_inc_raw    = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        done_raw      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                if (cnt == '0) begin
                    ir_write_raw = 1'b1;
                    pc_inc_raw   = 1'b1;
                    next_cnt     = RELOAD;
                    next_state   = S_DECODE;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (Jmp || Jal || Jr) begin
                    pc_write_raw  = 1'b1;
                    reg_write_raw = Jal;
                    done_raw      = 1'b1;
                    next_state    = S_FETCH;
                end else if (!legal_op) begin
                    illegal_raw = 1'b1;
                    done_raw    = 1'b1;
                    next_state  = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (Branch || nBranch) begin
                    pc_write_raw = Branch ? Zero : ~Zero;
                    done_raw     = 1'b1;
                    next_state   = S_FETCH;
                end else if (lw_op || sw_op) begin
                    next_cnt   = RELOAD;
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_read_raw = lw_op;
                if (cnt == '0) begin
                    next_cnt = RELOAD;
                    if (lw_op) begin
                        next_state = S_WB;
                    end else begin
                        mem_write_raw = sw_op;
                        done_raw      = 1'b1;
                        next_state    = S_FETCH;
                    end
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            default: begin
                next_cnt   = RELOAD;
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset and stall both suppress every strobe so nothing half-finished reaches the datapath
    assign block_strobes = reset || stall;
    assign MemRead    = mem_read_raw  && !block_strobes;
    assign IRWrite    = ir_write_raw  && !block_strobes;
    assign PCInc      = pc_inc_raw    && !block_strobes;
    assign PCWrite    = pc_write_raw  && !block_strobes;
    assign RegWrite   = reg_write_raw && !block_strobes;
    assign MemWrite   = mem_write_raw && !block_strobes;
    assign illegal    = illegal_raw   && !block_strobes;
    assign instr_done = done_raw      && !block_strobes;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= RELOAD;
        end else if (!stall) begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

endmodule

// File: tb/tb_multicycle_control32.sv
// Scoreboard bench for multicycle_control32: random instructions and stalls, per-instruction
// expectations from a reference model, checked by an independent monitor on instr_done.
module tb_multicycle_control32;

    localparam int L = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = '0;
    logic [5:0] Function_opcode = '0;
    logic       Zero = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] state;
    logic       MemRead, IRWrite, PCInc, PCWrite, RegWrite, MemWrite;
    logic       RegDST, ALUSrc, MemtoReg, Jr, Jmp, Jal, Branch, nBranch, I_format, Sftmd;
    logic [1:0] ALUOp;
    logic       illegal, instr_done;

    multicycle_control32 #(.MEM_LATENCY(L), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .Zero(Zero), .stall(stall), .state(state), .MemRead(MemRead), .IRWrite(IRWrite),
        .PCInc(PCInc), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .RegDST(RegDST), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .Jr(Jr), .Jmp(Jmp), .Jal(Jal),
        .Branch(Branch), .nBranch(nBranch), .I_format(I_format), .Sftmd(Sftmd), .ALUOp(ALUOp),
        .illegal(illegal), .instr_done(instr_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] timing;
        logic [31:0] strobes;
        logic [11:0] where;
        logic [11:0] levels;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   done_count = 0;
    bit   monitor_en = 1'b1;
    bit   stall_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [11:0] exp_levels(input logic [5:0] op, input logic [5:0] fn);
        logic r, i, lw, sw, beq, bne;
        r   = (op == 6'd0);
        i   = (op >= 6'd8 && op <= 6'd15);
        lw  = (op == 6'd35);
        sw  = (op == 6'd43);
        beq = (op == 6'd4);
        bne = (op == 6'd5);
        return {r, i | lw | sw, lw, r && fn == 6'd8, op == 6'd2, op == 6'd3, beq, bne, i,
                r && fn < 6'd8, r | i, beq | bne};
    endfunction

    // Reference model: per-state cycle counts, strobe counts and the state each strobe fires in
    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        rec_t e;
        bit is_r, is_jr, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_ill;
        int ex, mm, wb, nmr, npcw, nrw, nmw;
        int rw_st, mw_st, pcw_st;
        is_r   = (op == 6'd0) && (fn != 6'd8);
        is_jr  = (op == 6'd0) && (fn == 6'd8);
        is_i   = (op >= 6'd8) && (op <= 6'd15);
        is_lw  = (op == 6'd35);
        is_sw  = (op == 6'd43);
        is_beq = (op == 6'd4);
        is_bne = (op == 6'd5);
        is_j   = (op == 6'd2);
        is_jal = (op == 6'd3);
        is_ill = !(is_r || is_jr || is_i || is_lw || is_sw || is_beq || is_bne || is_j || is_jal);
        ex  = (is_r || is_i || is_lw || is_sw || is_beq || is_bne) ? 1 : 0;
        mm  = (is_lw || is_sw) ? L : 0;
        wb  = (is_r || is_i || is_lw) ? 1 : 0;
        nmr = L + (is_lw ? L : 0);
        nrw = (is_r || is_i || is_lw || is_jal) ? 1 : 0;
        rw_st = is_jal ? 1 : (nrw != 0 ? 4 : 7);
        nmw = is_sw ? 1 : 0;
        mw_st = is_sw ? 3 : 7;
        npcw = 0;
        pcw_st = 7;
        if (is_j || is_jal || is_jr) begin npcw = 1; pcw_st = 1; end
        if ((is_beq && z) || (is_bne && !z)) begin npcw = 1; pcw_st = 2; end
        e.timing  = {8'(L), 8'd1, 8'(ex), 8'(mm), 8'(wb)};
        e.strobes = {4'(nmr), 4'd1, 4'd1, 4'(npcw), 4'(nrw), 4'(nmw), 4'(is_ill ? 1 : 0), 4'(L - 1)};
        e.where   = {4'(rw_st), 4'(mw_st), 4'(pcw_st)};
        e.levels  = exp_levels(op, fn);
        return e;
    endfunction

    // Monitor: accumulates what the DUT does and compares against the queue on each instr_done
    initial begin
        int f, d, ex, mm, wb, nmr, nir, npci, npcw, nrw, nmw, nill, ir_idx, rw_st, mw_st, pcw_st, stall_bad;
        rec_t e;
        forever begin
            f = 0; d = 0; ex = 0; mm = 0; wb = 0; nmr = 0; nir = 0; npci = 0; npcw = 0;
            nrw = 0; nmw = 0; nill = 0; ir_idx = 15; rw_st = 7; mw_st = 7; pcw_st = 7; stall_bad = 0;
            forever begin
                @(negedge clock);
                if (reset || !monitor_en) break;
                if (stall) begin
                    if (MemRead | IRWrite | PCInc | PCWrite | RegWrite | MemWrite | illegal | instr_done)
                        stall_bad++;
                    continue;
                end
                case (state)
                    3'd0: begin if (IRWrite) ir_idx = f; f++; end
                    3'd1: d++;
                    3'd2: ex++;
                    3'd3: mm++;
                    3'd4: wb++;
                    default: ;
                endcase
                nmr += int'(MemRead); nir += int'(IRWrite); npci += int'(PCInc); nill += int'(illegal);
                if (RegWrite) begin nrw++; rw_st = int'(state); end
                if (MemWrite) begin nmw++; mw_st = int'(state); end
                if (PCWrite) begin npcw++; pcw_st = int'(state); end
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("timing", 64'({8'(f), 8'(d), 8'(ex), 8'(mm), 8'(wb)}), 64'(e.timing));
                        checkOutput("strobes", 64'({4'(nmr), 4'(nir), 4'(npci), 4'(npcw), 4'(nrw),
                                    4'(nmw), 4'(nill), 4'(ir_idx)}), 64'(e.strobes));
                        checkOutput("strobe_state", 64'({4'(rw_st), 4'(mw_st), 4'(pcw_st)}), 64'(e.where));
                        checkOutput("levels", 64'({RegDST, ALUSrc, MemtoReg, Jr, Jmp, Jal, Branch, nBranch,
                                    I_format, Sftmd, ALUOp}), 64'(e.levels));
                        checkOutput("stall_strobes", 64'(stall_bad), 64'd0);
                    end
                    done_count++;
                    break;
                end
            end
        end
    end

    // Random stall injection, only while enabled
    initial begin
        forever begin
            @(posedge clock);
            #1;
            stall = stall_en && ($urandom_range(0, 5) == 0);
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, output bit ok);
        int start;
        Opcode = op;
        Function_opcode = fn;
        Zero = z;
        exp_q.push_back(model(op, fn, z));
        start = done_count;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            if (done_count != start) begin ok = 1'b1; break; end
        end
        if (!ok) checkOutput("done_timeout", 64'd0, 64'd1);
        #1;
    endtask

    logic [5:0] dir_op[8] = '{6'd0, 6'd35, 6'd4, 6'd4, 6'd3, 6'd0, 6'd43, 6'h3f};
    logic [5:0] dir_fn[8] = '{6'h20, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd0, 6'd0};
    logic       dir_z[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] ill_ops[6] = '{6'h3f, 6'h01, 6'h10, 6'h20, 6'h28, 6'h33};
    logic [5:0] kind_ops[9] = '{6'd0, 6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};

    initial begin
        bit ok;
        int mem_seen;
        logic [5:0] op, fn;
        int k;
        ok = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("reset_state", 64'(state), 64'd0);
        checkOutput("reset_strobes", 64'({MemRead, IRWrite, PCInc, PCWrite, RegWrite, MemWrite,
                    illegal, instr_done}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int n = 0; n < 8 && ok; n++) applyStimulus(dir_op[n], dir_fn[n], dir_z[n], ok);

        stall_en = 1'b1;
        for (int n = 0; n < 40 && ok; n++) begin
            k = int'($urandom_range(0, 9));
            fn = 6'($urandom);
            if (k == 9) op = ill_ops[$urandom_range(0, 5)];
            else op = kind_ops[k];
            if (k == 2) op = {3'b001, 3'($urandom)};
            if (k == 0 && fn == 6'd8) fn = 6'h20;
            if (k == 1) fn = 6'd8;
            if (n == 39) stall_en = 1'b0;
            applyStimulus(op, fn, 1'($urandom), ok);
        end

        // Reset on the final MEM cycle of a sw must swallow the write
        if (ok) begin
            monitor_en = 1'b0;
            Opcode = 6'd43;
            Function_opcode = 6'd0;
            mem_seen = 0;
            for (int c = 0; c < 100 && mem_seen < L; c++) begin
                @(negedge clock);
                if (state == 3'd3 && !stall) mem_seen++;
            end
            checkOutput("mem_reached", 64'(mem_seen), 64'(L));
            checkOutput("pre_rst_memwrite", 64'(MemWrite), 64'd1);
            reset = 1'b1;
            #1;
            checkOutput("rst_memwrite", 64'(MemWrite), 64'd0);
            checkOutput("rst_done", 64'(instr_done), 64'd0);
            @(posedge clock);
            #1;
            checkOutput("rst_state", 64'(state), 64'd0);
            reset = 1'b0;
            monitor_en = 1'b1;
            applyStimulus(6'd0, 6'h20, 1'b0, ok);
        end

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
